// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial adder operand feeder.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } feed_state_e;

  localparam int SERIAL_WIDTH_DEFAULT = 8;

  // Bit-counter width; a one-bit floor keeps the counter declarable for tiny widths.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_piso.sv
// Parallel-load, LSB-first shift register with zero fill; sout is the current LSB.
module serial_piso #(
  parameter int WIDTH = serial_pkg::SERIAL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sh;

  // NOTE: the shift register is a handful of flops, not a RAM, so it takes the async reset like any other state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh <= '0;
    end else if (load) begin
      sh <= din;
    end else if (shift) begin
      sh <= {1'b0, sh[WIDTH-1:1]};
    end
  end

  assign sout = sh[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// Captures an operand pair, clears the serial adder for one cycle, then streams both operands LSB-first.
// Optional SERIAL_FEED_DONE_EN adds a one-cycle done pulse aligned with the adder's final carry.
module serial_operand_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             adder_clr,
  output logic             a_bit,
  output logic             b_bit,
  output logic             bit_valid,
  output logic             first_bit,
  output logic             last_bit,
  output logic             busy
`ifdef SERIAL_FEED_DONE_EN
  ,
  output logic             done
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  // For WIDTH=2 this is 0, which is also the first SHIFT count; the CLEAR/SHIFT split keeps them apart.
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

  feed_state_e      state, state_d;
  logic [CNT_W-1:0] cnt;
  logic             load, shift_en;
  logic             sa, sb;
  logic             clr_d, valid_d, a_d, b_d, first_d, last_d, busy_d, done_d;

  serial_piso #(.WIDTH(WIDTH)) u_piso_a (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift_en),
    .din   (op_a),
    .sout  (sa)
  );

  serial_piso #(.WIDTH(WIDTH)) u_piso_b (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift_en),
    .din   (op_b),
    .sout  (sb)
  );

  assign in_ready = (state == IDLE);

  // Outputs are registered, so each *_d value is what the next cycle presents.
  // The registers shift one cycle ahead (starting in CLEAR) so sout already holds the next bit.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    state_d  = state;
    load     = 1'b0;
    shift_en = 1'b0;
    clr_d    = 1'b0;
    valid_d  = 1'b0;
    a_d      = 1'b0;
    b_d      = 1'b0;
    first_d  = 1'b0;
    last_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = CLEAR;
          clr_d   = 1'b1;
        end
      end
      CLEAR: begin
        shift_en = 1'b1;
        state_d  = SHIFT;
        valid_d  = 1'b1;
        a_d      = sa;
        b_d      = sb;
        first_d  = 1'b1;
        last_d   = (WIDTH == 1);
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CNT_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          valid_d = 1'b1;
          a_d     = sa;
          b_d     = sb;
          last_d  = (cnt == CNT_PENULT);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (state == SHIFT && cnt != CNT_LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adder_clr <= 1'b0;
      bit_valid <= 1'b0;
      a_bit     <= 1'b0;
      b_bit     <= 1'b0;
      first_bit <= 1'b0;
      last_bit  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      adder_clr <= clr_d;
      bit_valid <= valid_d;
      a_bit     <= a_d;
      b_bit     <= b_d;
      first_bit <= first_d;
      last_bit  <= last_d;
      busy      <= busy_d;
    end
  end

`ifdef SERIAL_FEED_DONE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= done_d;
    end
  end
`else
  logic unused_done;
  assign unused_done = done_d;
`endif

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench for serial_operand_feeder (WIDTH=8) with a behavioural serial adder on the output stream.
module tb_serial_operand_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         in_ready, adder_clr, a_bit, b_bit, bit_valid, first_bit, last_bit, busy;
`ifdef SERIAL_FEED_DONE_EN
  logic         done;
`endif

  int vectors = 0;
  int miscompares = 0;

  serial_operand_feeder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .adder_clr (adder_clr),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .bit_valid (bit_valid),
    .first_bit (first_bit),
    .last_bit  (last_bit),
    .busy      (busy)
`ifdef SERIAL_FEED_DONE_EN
    ,
    .done      (done)
`endif
  );

  always #5 clk = ~clk;

  // Results of the most recent run_frame call.
  logic [W-1:0] r_abits, r_bbits, r_firsts, r_lasts, r_sum;
  logic         r_carry, r_accepted;
  int           r_clr, r_nbits, r_done_cnt, r_done_j;

  // Accepts one pair, then samples every negedge until the frame ends, feeding a serial adder model.
  // poke_j >= 0 pulses in_valid with new operands at that sample index (mid-frame).
  task automatic run_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int poke_j, input logic [W-1:0] pa, input logic [W-1:0] pb);
    int wait_cnt;
    r_abits = '0; r_bbits = '0; r_firsts = '0; r_lasts = '0; r_sum = '0;
    r_carry = 1'b0; r_clr = 0; r_nbits = 0; r_done_cnt = 0; r_done_j = -1;
    r_accepted = 1'b0;
    @(negedge clk);
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
      return;
    end
    r_accepted = 1'b1;
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      if (adder_clr) begin
        r_clr++;
        r_carry = 1'b0;
      end
      if (bit_valid) begin
        if (r_nbits < W) begin
          r_abits[r_nbits]  = a_bit;
          r_bbits[r_nbits]  = b_bit;
          r_firsts[r_nbits] = first_bit;
          r_lasts[r_nbits]  = last_bit;
          r_sum[r_nbits]    = a_bit ^ b_bit ^ r_carry;
          r_carry = (a_bit & b_bit) | (r_carry & (a_bit ^ b_bit));
        end
        r_nbits++;
      end
`ifdef SERIAL_FEED_DONE_EN
      if (done) begin
        r_done_cnt++;
        r_done_j = j;
      end
`endif
      if (j == poke_j) begin
        in_valid = 1'b1;
        op_a = pa;
        op_b = pb;
      end else if (j == poke_j + 1) begin
        in_valid = 1'b0;
      end
      if (j > 0 && !busy) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    rst = 1'b0;
    #2;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    // No in_valid: everything must stay idle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      outs = {adder_clr, a_bit, b_bit, bit_valid, first_bit, last_bit, busy, in_ready};
      vectors++;
      if (outs !== 8'b0000_0001) begin
        miscompares++;
        $display("FAIL idle_outputs cycle %0d: got %b required 00000001", i, outs);
      end
    end
  endtask

  task automatic test_basic();
    run_frame(8'hA5, 8'h3C, -1, '0, '0);
    vectors++;
    if (r_clr !== 1) begin
      miscompares++;
      $display("FAIL basic_clr_cycles: got %0d required 1", r_clr);
    end
    vectors++;
    if (r_nbits !== W) begin
      miscompares++;
      $display("FAIL basic_bit_count: got %0d required %0d", r_nbits, W);
    end
    vectors++;
    if (r_abits !== 8'hA5) begin
      miscompares++;
      $display("FAIL basic_a_stream: got %h required a5", r_abits);
    end
    vectors++;
    if (r_bbits !== 8'h3C) begin
      miscompares++;
      $display("FAIL basic_b_stream: got %h required 3c", r_bbits);
    end
    vectors++;
    if (r_firsts !== 8'h01) begin
      miscompares++;
      $display("FAIL basic_first_bit: got %b required 00000001", r_firsts);
    end
    vectors++;
    if (r_lasts !== 8'h80) begin
      miscompares++;
      $display("FAIL basic_last_bit: got %b required 10000000", r_lasts);
    end
    vectors++;
    if ({r_carry, r_sum} !== 9'h0E1) begin
      miscompares++;
      $display("FAIL basic_sum: got %b_%h required 0_e1", r_carry, r_sum);
    end
  endtask

  task automatic test_carry();
    run_frame(8'hFF, 8'h01, -1, '0, '0);
    vectors++;
    if ({r_carry, r_sum} !== 9'h100) begin
      miscompares++;
      $display("FAIL carry_ff_01: got %b_%h required 1_00", r_carry, r_sum);
    end
    run_frame(8'h00, 8'h00, -1, '0, '0);
    vectors++;
    if (r_clr !== 1) begin
      miscompares++;
      $display("FAIL carry_clear_seen: got %0d required 1", r_clr);
    end
    vectors++;
    if ({r_carry, r_sum} !== 9'h000) begin
      miscompares++;
      $display("FAIL carry_cleared: got %b_%h required 0_00", r_carry, r_sum);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pa [3] = '{8'h11, 8'hF0, 8'h80};
    logic [W-1:0] pb [3] = '{8'h22, 8'h0F, 8'h80};
    logic [8:0]   expect_sum [3] = '{9'h033, 9'h0FF, 9'h100};
    logic [W-1:0] sums [3];
    logic         carries [3];
    int           nb [3];
    int           acc [3];
    int           idx = 0;
    int           fr = -1;
    int           rdy_bad = 0;
    logic         c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sums[i] = '0; carries[i] = 1'b0; nb[i] = 0; acc[i] = -1;
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (in_ready !== !(adder_clr | bit_valid)) rdy_bad++;
      if (adder_clr) begin
        fr++;
        c = 1'b0;
      end
      if (bit_valid && fr >= 0 && fr < 3) begin
        if (nb[fr] < W) begin
          sums[fr][nb[fr]] = a_bit ^ b_bit ^ c;
          c = (a_bit & b_bit) | (c & (a_bit ^ b_bit));
          carries[fr] = c;
        end
        nb[fr]++;
      end
      if (idx < 3) begin
        in_valid = 1'b1;
        op_a = pa[idx];
        op_b = pb[idx];
        if (in_ready) begin
          acc[idx] = cyc;
          idx++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (rdy_bad !== 0) begin
      miscompares++;
      $display("FAIL b2b_in_ready: %0d cycles where in_ready != not(clr|valid), required 0", rdy_bad);
    end
    for (int i = 1; i < 3; i++) begin
      vectors++;
      if (acc[i] - acc[i-1] !== W + 2) begin
        miscompares++;
        $display("FAIL b2b_spacing %0d: got %0d required %0d", i, acc[i] - acc[i-1], W + 2);
      end
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (nb[i] !== W || {carries[i], sums[i]} !== expect_sum[i]) begin
        miscompares++;
        $display("FAIL b2b_frame %0d: got bits=%0d sum=%b_%h required bits=%0d sum=%h",
                 i, nb[i], carries[i], sums[i], W, expect_sum[i]);
      end
    end
  endtask

  task automatic test_ignore_midframe();
    run_frame(8'hA5, 8'h3C, 4, 8'h00, 8'hFF);
    vectors++;
    if (r_abits !== 8'hA5 || r_bbits !== 8'h3C || r_nbits !== W) begin
      miscompares++;
      $display("FAIL midframe_stream: got a=%h b=%h bits=%0d required a=a5 b=3c bits=8",
               r_abits, r_bbits, r_nbits);
    end
    vectors++;
    if (r_clr !== 1) begin
      miscompares++;
      $display("FAIL midframe_clr: got %0d required 1", r_clr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || adder_clr !== 1'b0) begin
        miscompares++;
        $display("FAIL midframe_no_accept cycle %0d: got busy=%b clr=%b required 0 0", i, busy, adder_clr);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] outs;
    @(negedge clk);
    in_valid = 1'b1;
    op_a = 8'hC3;
    op_b = 8'h5A;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if (bit_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_in_shift: got bit_valid=%b busy=%b required 1 1", bit_valid, busy);
    end
    #1 rst = 1'b0;
    #1;
    outs = {adder_clr, a_bit, b_bit, bit_valid, first_bit, last_bit, busy, in_ready};
    vectors++;
    if (outs !== 8'b0000_0001) begin
      miscompares++;
      $display("FAIL rstmid_async: got %b required 00000001", outs);
    end
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    run_frame(8'h12, 8'h34, -1, '0, '0);
    vectors++;
    if ({r_carry, r_sum} !== 9'h046 || r_nbits !== W) begin
      miscompares++;
      $display("FAIL rstmid_restart: got %b_%h bits=%0d required 0_46 bits=8", r_carry, r_sum, r_nbits);
    end
  endtask

`ifdef SERIAL_FEED_DONE_EN
  task automatic test_done();
    run_frame(8'h5A, 8'hA5, -1, '0, '0);
    vectors++;
    if (r_done_cnt !== 1 || r_done_j !== W + 1) begin
      miscompares++;
      $display("FAIL done_pulse: got count=%0d at sample %0d required count=1 at sample %0d",
               r_done_cnt, r_done_j, W + 1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
`ifdef SERIAL_FEED_DONE_EN
    test_done();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_operand_feeder.md
Name: serial_operand_feeder

Overview:
- Upstream stage of the serial adder.
- Accepts two WIDTH-bit operands through a valid/ready handshake.
- Issues a one-cycle adder clear, then shifts both operands out LSB-first, one bit pair per clock, onto the adder's a/b inputs.
- Frame markers (first/last) let the downstream collector align sum bits and the final carry.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock, shared with the serial adder
rst  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair on op_a/op_b is valid
in_ready  output  1  block can accept an operand pair
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
adder_clr  output  1  active-high synchronous clear to the serial adder's rst input
a_bit  output  1  current serial bit of A, to adder a
b_bit  output  1  current serial bit of B, to adder b
bit_valid  output  1  a_bit/b_bit carry a live operand bit
first_bit  output  1  high with bit 0 (LSB)
last_bit  output  1  high with bit WIDTH-1 (MSB)
busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset: while rst=0, asynchronously force state=IDLE, shift registers=0 and bit counter=0.
- Reset values: adder_clr=0, a_bit=0, b_bit=0, bit_valid=0, first_bit=0, last_bit=0, busy=0.
- in_ready is combinational: in_ready = (state==IDLE). It is therefore 1 during reset.
- All other outputs are registered.
- FSM states are IDLE, CLEAR and SHIFT.
- IDLE: if in_valid && in_ready at edge k, load sh_a<=op_a, sh_b<=op_b and cnt<=0, then go to CLEAR. Otherwise hold.
- CLEAR (cycle k+1): adder_clr=1, bit_valid=0, a_bit=b_bit=0. The adder samples the clear at edge k+2 so its carry is 0. Next state is SHIFT.
- SHIFT (cycles k+2 .. k+1+WIDTH):
  - Outputs: a_bit=sh_a[0], b_bit=sh_b[0], bit_valid=1.
  - first_bit is high when cnt==0; last_bit is high when cnt==WIDTH-1.
  - Each edge: shift both registers right by one (zero fill) and increment cnt.
  - At the edge that ends the cnt==WIDTH-1 cycle, go to IDLE.
- Latency:
  - Bit i is presented in cycle k+2+i.
  - The adder's registered sum for bit i appears in cycle k+3+i.
  - The final carry is valid in cycle k+2+WIDTH.
- Throughput: one operand pair per WIDTH+2 cycles. The next accept is possible at the edge ending cycle k+2+WIDTH.
- in_valid while busy is ignored. op_a/op_b may change mid-frame without effect, because operands are captured at accept.
- No in_valid when idle: outputs stay at reset values and adder_clr stays 0.
- cnt width is $clog2(WIDTH). No wrap occurs, because the frame ends at WIDTH-1.
- Reset mid-frame: the frame is aborted immediately and the block restarts in IDLE. The adder's own reset is driven separately by system reset.

Optional Feature:
- Macro: SERIAL_FEED_DONE_EN.
- When defined: adds output port done (1 bit, reset 0). done pulses high for exactly one cycle, cycle k+2+WIDTH, the cycle in which the adder's final sum bit and carry are valid. It must be asserted even if the next in_valid is accepted in that same cycle.
- When undefined: no done port, and logic is identical otherwise.

Decomposition:
- Shared package serial_pkg holds:
  - the state enum (IDLE, CLEAR, SHIFT);
  - a localparam for the default operand width;
  - a function computing counter width from WIDTH.
- One natural sub-module: serial_piso. It is a WIDTH-bit parallel-load, LSB-first shift register with load and shift enables, instantiated twice (A and B).

Test Plan:
1. WIDTH=8, op_a=8'hA5, op_b=8'h3C, in_valid one cycle. Required response:
   - adder_clr high for exactly 1 cycle.
   - a_bit sequence 1,0,1,0,0,1,0,1 and b_bit sequence 0,0,1,1,1,1,0,0.
   - first_bit on bit 0, last_bit on bit 7.
   - The attached adder's collected sum is 8'hE1 with carry 0.
2. op_a=8'hFF, op_b=8'h01 -> collected sum 8'h00 with final carry 1. A following pair 8'h00+8'h00 gives carry 0, proving the clear works.
3. in_valid held high with 3 distinct operand pairs -> accepts spaced exactly WIDTH+2=10 cycles apart, in_ready low during CLEAR/SHIFT, no bits lost or duplicated.
4. Change op_a/op_b and pulse in_valid during SHIFT -> the serial stream is unchanged and the second pulse is not accepted.
5. Deassert rst in the middle of SHIFT (bit 4). Required response:
   - All outputs go to 0 immediately, without waiting for a clock.
   - in_ready goes to 1.
   - After release, a new pair 8'h12+8'h34 produces sum 8'h46.
6. With SERIAL_FEED_DONE_EN defined -> done is a single-cycle pulse, 10 cycles after accept, coincident with the final carry being valid. The build without the macro has no done port.
